// File: rtl/result_fifo_bridge_if.sv
// result_fifo_bridge_if: result word stream from the TPU datapath into the bridge
interface result_fifo_bridge_if #(parameter int DATA_W = 32);
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [1:0]        res_ec;
  logic [19:0]       res_dig_err;
  modport master(output res_valid, res_data, res_ec, res_dig_err, input res_ready);
  modport slave(input res_valid, res_data, res_ec, res_dig_err, output res_ready);
endinterface

// File: rtl/result_fifo_bridge.sv
// result_fifo_bridge: buffers result words for software to drain via PIO, with sticky error status
module result_fifo_bridge #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  result_fifo_bridge_if.slave       res,
  input  logic [7:0]                ctrl,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ADDR_W:0]           fifo_used,
  output logic [2:0]                ec_flags,
  output logic [19:0]               dig_error
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              ctrl0_q, ram_v, clear, full, accept, pop, ctrl_unused;
  assign ctrl_unused   = ^ctrl[7:2];
  assign clear         = ctrl[1];
  assign full          = fifo_used == DEPTH;
  assign res.res_ready = !reset_reset && !full;
  assign accept        = res.res_valid && res.res_ready && !clear;
  assign pop           = ctrl[0] && !ctrl0_q && !clear && fifo_used != '0;
  // pop edge detector; only reset clears it so a held bit never re-fires after clear
  always_ff @(posedge clk_clk)
    ctrl0_q <= reset_reset ? 1'b0 : ctrl[0];
  // storage with registered read of the current head address
  always_ff @(posedge clk_clk) begin
    if (accept) mem[wr_ptr] <= res.res_data;
    ram_q <= mem[rd_ptr];
  end
  // pointers, occupancy, sticky status and head prefetch; ram_v marks ram_q as a real head
  always_ff @(posedge clk_clk)
    if (reset_reset || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_used <= '0;
      ec_flags  <= '0;
      dig_error <= '0;
      rd_data   <= '0;
      ram_v     <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_used <= (accept && !pop) ? fifo_used + 1'b1 : (pop && !accept) ? fifo_used - 1'b1 : fifo_used;
      ec_flags  <= ec_flags | {res.res_valid && full, accept ? res.res_ec : 2'b00};
      if (accept && res.res_ec != 2'b00 && ec_flags[1:0] == 2'b00) dig_error <= res.res_dig_err;
      ram_v <= fifo_used != '0;
      if (ram_v) rd_data <= ram_q;
    end
endmodule

// File: tb/tb_result_fifo_bridge.sv
// tb_result_fifo_bridge: directed self-checking bench for result_fifo_bridge
module tb_result_fifo_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ctrl = 8'd0;
  logic [31:0] rd_data;
  logic [9:0]  fifo_used;
  logic [2:0]  ec_flags;
  logic [19:0] dig_error;
  int checks = 0;
  int errors = 0;
  result_fifo_bridge_if #(.DATA_W(32)) rif();
  result_fifo_bridge #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk_clk(clk), .reset_reset(rst), .res(rif.slave), .ctrl(ctrl),
    .rd_data(rd_data), .fifo_used(fifo_used), .ec_flags(ec_flags), .dig_error(dig_error)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] d, input logic [1:0] e, input logic [19:0] g);
    rif.res_valid = v;
    rif.res_data = d;
    rif.res_ec = e;
    rif.res_dig_err = g;
  endtask
  task automatic do_clear();
    ctrl = 8'h02;
    cyc();
    ctrl = 8'h00;
  endtask
  task automatic test_reset();
    drive(1'b0, 32'h0, 2'b00, 20'h0);
    rst = 1'b1;
    repeat (3) cyc();
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp %h", rd_data, 32'h0); end
    checks++; if (fifo_used !== 10'd0) begin errors++; $display("FAIL reset_used got %0d exp 0", fifo_used); end
    checks++; if (ec_flags !== 3'b000) begin errors++; $display("FAIL reset_ec got %b exp 000", ec_flags); end
    checks++; if (dig_error !== 20'h0) begin errors++; $display("FAIL reset_dig got %h exp 0", dig_error); end
    checks++; if (rif.res_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", rif.res_ready); end
    rst = 1'b0;
    cyc();
    checks++; if (rif.res_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", rif.res_ready); end
  endtask
  task automatic test_push3();
    drive(1'b1, 32'h11111111, 2'b00, 20'h0);
    cyc();
    checks++; if (fifo_used !== 10'd1) begin errors++; $display("FAIL push1_used got %0d exp 1", fifo_used); end
    rif.res_data = 32'h22222222;
    cyc();
    checks++; if (fifo_used !== 10'd2) begin errors++; $display("FAIL push2_used got %0d exp 2", fifo_used); end
    rif.res_data = 32'h33333333;
    cyc();
    checks++; if (fifo_used !== 10'd3) begin errors++; $display("FAIL push3_used got %0d exp 3", fifo_used); end
    checks++; if (rd_data !== 32'h11111111) begin errors++; $display("FAIL push_head got %h exp 11111111", rd_data); end
    rif.res_valid = 1'b0;
  endtask
  task automatic test_pop();
    ctrl = 8'h01;
    cyc();
    checks++; if (fifo_used !== 10'd2) begin errors++; $display("FAIL pop1_used got %0d exp 2", fifo_used); end
    cyc();
    checks++; if (rd_data !== 32'h11111111 && rd_data !== 32'h22222222) begin errors++; $display("FAIL pop1_between got %h exp 11111111 or 22222222", rd_data); end
    cyc();
    checks++; if (rd_data !== 32'h22222222) begin errors++; $display("FAIL pop1_head got %h exp 22222222", rd_data); end
    repeat (2) cyc();
    checks++; if (fifo_used !== 10'd2) begin errors++; $display("FAIL pop1_hold_used got %0d exp 2", fifo_used); end
    ctrl = 8'h00;
    cyc();
    ctrl = 8'h01;
    cyc();
    checks++; if (fifo_used !== 10'd1) begin errors++; $display("FAIL pop2_used got %0d exp 1", fifo_used); end
    repeat (2) cyc();
    checks++; if (rd_data !== 32'h33333333) begin errors++; $display("FAIL pop2_head got %h exp 33333333", rd_data); end
    repeat (2) cyc();
    checks++; if (fifo_used !== 10'd1) begin errors++; $display("FAIL pop2_hold_used got %0d exp 1", fifo_used); end
    ctrl = 8'h00;
    cyc();
    ctrl = 8'h01;
    cyc();
    checks++; if (fifo_used !== 10'd0) begin errors++; $display("FAIL pop3_used got %0d exp 0", fifo_used); end
    ctrl = 8'h00;
    repeat (3) cyc();
    checks++; if (rd_data !== 32'h33333333) begin errors++; $display("FAIL empty_hold got %h exp 33333333", rd_data); end
  endtask
  task automatic test_full();
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, i, 2'b00, 20'h0);
      cyc();
    end
    checks++; if (fifo_used !== 10'd512) begin errors++; $display("FAIL full_used got %0d exp 512", fifo_used); end
    checks++; if (rif.res_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", rif.res_ready); end
    checks++; if (ec_flags !== 3'b000) begin errors++; $display("FAIL full_ec_pre got %b exp 000", ec_flags); end
    rif.res_data = 32'hDEADBEEF;
    cyc();
    rif.res_valid = 1'b0;
    checks++; if (fifo_used !== 10'd512) begin errors++; $display("FAIL ovf_used got %0d exp 512", fifo_used); end
    checks++; if (ec_flags !== 3'b100) begin errors++; $display("FAIL ovf_ec got %b exp 100", ec_flags); end
    cyc();
    for (int i = 0; i < 512; i++) begin
      checks++; if (rd_data !== 32'(i)) begin errors++; $display("FAIL drain_%0d got %h exp %h", i, rd_data, 32'(i)); end
      ctrl = 8'h01;
      cyc();
      ctrl = 8'h00;
      repeat (2) cyc();
    end
    checks++; if (fifo_used !== 10'd0) begin errors++; $display("FAIL drain_used got %0d exp 0", fifo_used); end
    checks++; if (rd_data !== 32'd511) begin errors++; $display("FAIL drain_hold got %h exp %h", rd_data, 32'd511); end
  endtask
  task automatic test_ec();
    do_clear();
    checks++; if (ec_flags !== 3'b000) begin errors++; $display("FAIL ec_clear got %b exp 000", ec_flags); end
    drive(1'b1, 32'h1, 2'b00, 20'h12345);
    cyc();
    checks++; if (dig_error !== 20'h0) begin errors++; $display("FAIL ec00_dig got %h exp 0", dig_error); end
    drive(1'b1, 32'h2, 2'b01, 20'h0000A);
    cyc();
    checks++; if (ec_flags !== 3'b001) begin errors++; $display("FAIL ec01_flags got %b exp 001", ec_flags); end
    checks++; if (dig_error !== 20'h0000A) begin errors++; $display("FAIL ec01_dig got %h exp 0000a", dig_error); end
    drive(1'b1, 32'h3, 2'b10, 20'h0000B);
    cyc();
    drive(1'b0, 32'h0, 2'b00, 20'h0);
    checks++; if (ec_flags !== 3'b011) begin errors++; $display("FAIL ec10_flags got %b exp 011", ec_flags); end
    checks++; if (dig_error !== 20'h0000A) begin errors++; $display("FAIL ec10_dig got %h exp 0000a", dig_error); end
  endtask
  task automatic test_same_edge();
    do_clear();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h100 + i, 2'b00, 20'h0);
      cyc();
    end
    checks++; if (fifo_used !== 10'd5) begin errors++; $display("FAIL se_fill got %0d exp 5", fifo_used); end
    rif.res_data = 32'h105;
    ctrl = 8'h01;
    cyc();
    rif.res_valid = 1'b0;
    ctrl = 8'h00;
    checks++; if (fifo_used !== 10'd5) begin errors++; $display("FAIL se_used got %0d exp 5", fifo_used); end
    repeat (2) cyc();
    checks++; if (rd_data !== 32'h101) begin errors++; $display("FAIL se_head got %h exp 101", rd_data); end
    do_clear();
    ctrl = 8'h01;
    cyc();
    checks++; if (fifo_used !== 10'd0) begin errors++; $display("FAIL underflow_used got %0d exp 0", fifo_used); end
    checks++; if (rif.res_ready !== 1'b1) begin errors++; $display("FAIL underflow_ready got %b exp 1", rif.res_ready); end
    ctrl = 8'h00;
    drive(1'b1, 32'hCAFE0001, 2'b00, 20'h0);
    cyc();
    rif.res_valid = 1'b0;
    checks++; if (fifo_used !== 10'd1) begin errors++; $display("FAIL underflow_push got %0d exp 1", fifo_used); end
    repeat (2) cyc();
    checks++; if (rd_data !== 32'hCAFE0001) begin errors++; $display("FAIL underflow_head got %h exp cafe0001", rd_data); end
  endtask
  task automatic test_clear();
    do_clear();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'h200 + i, (i == 0) ? 2'b01 : 2'b00, 20'h5);
      cyc();
    end
    checks++; if (fifo_used !== 10'd7) begin errors++; $display("FAIL clr_fill got %0d exp 7", fifo_used); end
    drive(1'b1, 32'h207, 2'b10, 20'h6);
    ctrl = 8'h02;
    cyc();
    checks++; if (fifo_used !== 10'd0) begin errors++; $display("FAIL clr_used got %0d exp 0", fifo_used); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL clr_rd got %h exp 0", rd_data); end
    checks++; if (ec_flags !== 3'b000) begin errors++; $display("FAIL clr_ec got %b exp 000", ec_flags); end
    checks++; if (dig_error !== 20'h0) begin errors++; $display("FAIL clr_dig got %h exp 0", dig_error); end
    checks++; if (rif.res_ready !== 1'b1) begin errors++; $display("FAIL clr_ready got %b exp 1", rif.res_ready); end
    ctrl = 8'h00;
    drive(1'b1, 32'h300, 2'b00, 20'h0);
    cyc();
    rif.res_valid = 1'b0;
    checks++; if (fifo_used !== 10'd1) begin errors++; $display("FAIL clr_push got %0d exp 1", fifo_used); end
    repeat (2) cyc();
    checks++; if (rd_data !== 32'h300) begin errors++; $display("FAIL clr_head got %h exp 300", rd_data); end
  endtask
  task automatic test_reset_mid();
    do_clear();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h400 + i, 2'b10, 20'h7);
      cyc();
    end
    checks++; if (ec_flags !== 3'b010) begin errors++; $display("FAIL mid_ec got %b exp 010", ec_flags); end
    checks++; if (dig_error !== 20'h7) begin errors++; $display("FAIL mid_dig got %h exp 7", dig_error); end
    rst = 1'b1;
    cyc();
    checks++; if (fifo_used !== 10'd0) begin errors++; $display("FAIL mid_rst_used got %0d exp 0", fifo_used); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL mid_rst_rd got %h exp 0", rd_data); end
    checks++; if (ec_flags !== 3'b000) begin errors++; $display("FAIL mid_rst_ec got %b exp 000", ec_flags); end
    checks++; if (dig_error !== 20'h0) begin errors++; $display("FAIL mid_rst_dig got %h exp 0", dig_error); end
    checks++; if (rif.res_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", rif.res_ready); end
    rst = 1'b0;
    drive(1'b1, 32'h500, 2'b00, 20'h0);
    cyc();
    rif.res_valid = 1'b0;
    checks++; if (fifo_used !== 10'd1) begin errors++; $display("FAIL mid_push got %0d exp 1", fifo_used); end
    repeat (2) cyc();
    checks++; if (rd_data !== 32'h500) begin errors++; $display("FAIL mid_head got %h exp 500", rd_data); end
  endtask
  initial begin
    test_reset();
    test_push3();
    test_pop();
    test_full();
    test_ec();
    test_same_edge();
    test_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
